// File: rtl/bin_window_3x3_gen_if.sv
// Stream/result bundle between a binary pixel source and bin_window_3x3_gen.
// The master drives pixels and weights; the slave (the window generator) returns patches and status.
interface bin_window_3x3_gen_if;
    logic       pix_valid;
    logic       pix_bit;
    logic       weight_load;
    logic [8:0] weight_in;
    logic [8:0] patch_bits;
    logic [8:0] weight_bits;
    logic       valid_out;
    logic       frame_done;
    logic       busy;

    modport master (
        output pix_valid, pix_bit, weight_load, weight_in,
        input  patch_bits, weight_bits, valid_out, frame_done, busy
    );

    modport slave (
        input  pix_valid, pix_bit, weight_load, weight_in,
        output patch_bits, weight_bits, valid_out, frame_done, busy
    );
endinterface

// File: rtl/bin_window_3x3_gen.sv
// Buffers two rows of a raster binary stream and emits every valid 3x3 patch with the held kernel.
// Define WIN_COORD_EN to add win_row/win_col outputs giving each patch's top-left coordinate.
module bin_window_3x3_gen #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int COL_W      = $clog2(IMG_WIDTH),
    parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    bin_window_3x3_gen_if.slave   bus
`ifdef WIN_COORD_EN
    ,
    output logic [ROW_W-1:0]      win_row,
    output logic [COL_W-1:0]      win_col
`endif
);

    typedef enum logic {IDLE, STREAM} state_e;

    state_e               state_q, state_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [IMG_WIDTH-1:0] rowPrev_q;
    logic [IMG_WIDTH-1:0] rowPrev2_q;
    logic [8:0]           win_q, win_d;
    logic [8:0]           patch_q;
    logic [8:0]           weight_q;
    logic                 valid_q;
    logic                 done_q;
    logic                 accept;
    logic                 lastCol;
    logic                 lastRow;
    logic                 lastPix;
    logic                 winValid;

    // The window shifts left one column per pixel; the new right column is {row r-2, row r-1, pixel}.
    always_comb begin
        accept   = bus.pix_valid;
        lastCol  = (col_q == COL_W'(IMG_WIDTH - 1));
        lastRow  = (row_q == ROW_W'(IMG_HEIGHT - 1));
        lastPix  = accept && lastCol && lastRow;
        winValid = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
        win_d    = {win_q[7:6], rowPrev2_q[col_q],
                    win_q[4:3], rowPrev_q[col_q],
                    win_q[1:0], bus.pix_bit};
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        if (accept) begin
            if (lastCol) begin
                col_d = '0;
                row_d = lastRow ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        case (state_q)
            IDLE:    if (accept)  state_d = STREAM;
            STREAM:  if (lastPix) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            patch_q  <= '0;
            weight_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            valid_q <= winValid;
            done_q  <= lastPix;
            if (winValid) begin
                patch_q <= win_d;
            end
            if (bus.weight_load && (state_q == IDLE)) begin
                weight_q <= bus.weight_in;
            end
        end
    end

    // Line buffers and window carry no reset: nothing reaches the outputs until two fresh rows exist.
    always_ff @(posedge clk) begin
        if (accept) begin
            win_q             <= win_d;
            rowPrev_q[col_q]  <= bus.pix_bit;
            rowPrev2_q[col_q] <= rowPrev_q[col_q];
        end
    end

`ifdef WIN_COORD_EN
    logic [ROW_W-1:0] winRow_q;
    logic [COL_W-1:0] winCol_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            winRow_q <= '0;
            winCol_q <= '0;
        end else if (winValid) begin
            winRow_q <= row_q - ROW_W'(2);
            winCol_q <= col_q - COL_W'(2);
        end
    end

    assign win_row = winRow_q;
    assign win_col = winCol_q;
`endif

    assign bus.patch_bits  = patch_q;
    assign bus.weight_bits = weight_q;
    assign bus.valid_out   = valid_q;
    assign bus.frame_done  = done_q;
    assign bus.busy        = (state_q == STREAM);

endmodule

// File: tb/tb_bin_window_3x3_gen.sv
// Self-checking bench for bin_window_3x3_gen on a 4x4 image: table-driven frames plus randomized
// frames checked against an image-array reference model. Checks win_row/win_col when WIN_COORD_EN is set.
module tb_bin_window_3x3_gen;
    localparam int W = 4;
    localparam int H = 4;

    typedef struct {
        string           name;
        logic [15:0]     pix;
        logic [3:0][8:0] exp;
    } frameVec_t;

    logic clk;
    logic reset;

    bin_window_3x3_gen_if bus();

`ifdef WIN_COORD_EN
    logic [1:0] win_row;
    logic [1:0] win_col;
`endif

    bin_window_3x3_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef WIN_COORD_EN
        ,
        .win_row (win_row),
        .win_col (win_col)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    bit         img [H][W];
    int         mr;
    int         mc;
    bit         inFrame;
    logic [8:0] wExp;
    logic [8:0] expPatch;
    int         expRow;
    int         expCol;
    logic [8:0] seenQ [$];
    frameVec_t  vecs [5];

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] refPatch(input int r, input int c);
        logic [8:0] p;
        p = '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                p[8 - (dr * 3 + dc)] = img[r - 2 + dr][c - 2 + dc];
            end
        end
        return p;
    endfunction

    task automatic checkAll(input bit expValid, input bit expDone);
        checkOutput("valid_out", 32'(bus.valid_out), 32'(expValid));
        checkOutput("frame_done", 32'(bus.frame_done), 32'(expDone));
        checkOutput("busy", 32'(bus.busy), 32'(inFrame));
        checkOutput("weight_bits", 32'(bus.weight_bits), 32'(wExp));
        checkOutput("patch_bits", 32'(bus.patch_bits), 32'(expPatch));
`ifdef WIN_COORD_EN
        checkOutput("win_row", 32'(win_row), 32'(expRow));
        checkOutput("win_col", 32'(win_col), 32'(expCol));
`endif
    endtask

    task automatic applyReset();
        reset           = 1'b1;
        bus.pix_valid   = 1'b0;
        bus.pix_bit     = 1'b0;
        bus.weight_load = 1'b0;
        bus.weight_in   = 9'h000;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        mr       = 0;
        mc       = 0;
        inFrame  = 1'b0;
        wExp     = 9'h000;
        expPatch = 9'h000;
        expRow   = 0;
        expCol   = 0;
        checkAll(1'b0, 1'b0);
    endtask

    // One clock of stimulus; the model predicts the outputs registered on that edge.
    task automatic applyStimulus(input bit v, input bit b, input bit wl, input logic [8:0] wi);
        bit expValid;
        bit expDone;
        bus.pix_valid   = v;
        bus.pix_bit     = b;
        bus.weight_load = wl;
        bus.weight_in   = wi;
        expValid = 1'b0;
        expDone  = 1'b0;
        if (wl && !inFrame) wExp = wi;
        if (v) begin
            img[mr][mc] = b;
            if (mr >= 2 && mc >= 2) begin
                expValid = 1'b1;
                expPatch = refPatch(mr, mc);
                expRow   = mr - 2;
                expCol   = mc - 2;
            end
            expDone = (mr == H - 1) && (mc == W - 1);
            inFrame = !expDone;
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end
        end
        @(posedge clk);
        #1;
        checkAll(expValid, expDone);
        if (bus.valid_out) seenQ.push_back(bus.patch_bits);
        bus.pix_valid   = 1'b0;
        bus.weight_load = 1'b0;
    endtask

    task automatic sendFrame(input logic [15:0] pix, input int maxGap, input bit midLoad,
                             input bit firstLoad, input logic [8:0] firstW, output int firstPulse);
        int gaps;
        seenQ.delete();
        firstPulse = -1;
        for (int i = 0; i < 16; i++) begin
            gaps = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
            for (int g = 0; g < gaps; g++) applyStimulus(1'b0, 1'b0, 1'b0, 9'h000);
            applyStimulus(1'b1, pix[i], (midLoad && i == 5) || (firstLoad && i == 0),
                          (i == 0) ? firstW : 9'h0F0);
            if (bus.valid_out && firstPulse < 0) firstPulse = i + 1;
        end
    endtask

    task automatic checkFrame(input frameVec_t v, input int firstPulse);
        logic [31:0] act;
        checkOutput({v.name, " first_pulse_pixel"}, 32'(firstPulse), 32'd11);
        checkOutput({v.name, " pulse_count"}, 32'(seenQ.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            act = (k < seenQ.size()) ? 32'(seenQ[k]) : 32'hFFFF_FFFF;
            checkOutput($sformatf("%s patch%0d", v.name, k), act, 32'(v.exp[k]));
        end
    endtask

    initial begin
        int fp;
        logic [8:0] w;

        vecs[0] = '{"all_ones",    16'hFFFF, {9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF}};
        vecs[1] = '{"checker",     16'h5A5A, {9'h0AA, 9'h155, 9'h155, 9'h0AA}};
        vecs[2] = '{"pixel_3_3",   16'h8000, {9'h001, 9'h000, 9'h000, 9'h000}};
        vecs[3] = '{"pixel_0_0",   16'h0001, {9'h000, 9'h000, 9'h000, 9'h100}};
        vecs[4] = '{"pixel_1_1",   16'h0020, {9'h100, 9'h080, 9'h020, 9'h010}};

        applyReset();

        applyStimulus(1'b0, 1'b0, 1'b1, 9'h1FF);
        checkOutput("weight_load_idle", 32'(bus.weight_bits), 32'h1FF);

        for (int t = 0; t < 5; t++) begin
            sendFrame(vecs[t].pix, 0, 1'b0, 1'b0, 9'h000, fp);
            checkFrame(vecs[t], fp);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 9'h000);
        checkOutput("busy_after_frames", 32'(bus.busy), 32'd0);

        $display("[TB] checkerboard with random gaps");
        for (int t = 0; t < 3; t++) begin
            sendFrame(vecs[1].pix, 3, 1'b0, 1'b0, 9'h000, fp);
            checkFrame(vecs[1], fp);
        end

        $display("[TB] weight load in stream and idle");
        sendFrame(vecs[1].pix, 0, 1'b1, 1'b0, 9'h000, fp);
        checkOutput("weight_kept_in_stream", 32'(bus.weight_bits), 32'h1FF);
        applyStimulus(1'b0, 1'b0, 1'b1, 9'h0F0);
        checkOutput("weight_load_after_stream", 32'(bus.weight_bits), 32'h0F0);
        sendFrame(vecs[1].pix, 0, 1'b0, 1'b1, 9'h133, fp);
        checkOutput("weight_with_first_pixel", 32'(bus.weight_bits), 32'h133);

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 1'b0, 9'h000);
        applyReset();
        sendFrame(vecs[1].pix, 0, 1'b0, 1'b0, 9'h000, fp);
        checkFrame(vecs[1], fp);

        $display("[TB] randomized frames");
        for (int f = 0; f < 25; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                w = 9'($urandom_range(0, 511));
                applyStimulus(1'b0, 1'b0, 1'b1, w);
            end
            w = 9'($urandom_range(0, 511));
            sendFrame(16'($urandom_range(0, 65535)), 2, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), w, fp);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) applyStimulus(1'b0, 1'b0, 1'b0, 9'h000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
